// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage. Owns the fetch PC, drives a request/ready
//   instruction-memory port and loads the IF/ID pipeline register with
//   {valid, pc, pc+4, instr}. Handles hazard stalls and branch/jump redirects,
//   including redirects that land while a memory request is still waiting.
//
// Parameters
//   RESET_PC       first fetch address after reset (word aligned)
//
// Ports
//   clk_i          rising-edge clock
//   rst_n_i        synchronous active-low reset
//   stall_i        hazard unit: hold IF/ID and PC
//   redirect_i     taken branch/jump this cycle
//   redirect_pc_i  redirect target, bits [1:0] ignored
//   imem_req_o     fetch request
//   imem_addr_o    fetch address (always equals pc_o)
//   imem_ready_i   memory completes the request this cycle
//   imem_rdata_i   instruction word, valid with imem_req_o && imem_ready_i
//   pc_o           current fetch PC
//   ifid_valid_o   IF/ID holds a live instruction
//   ifid_pc_o      address of ifid_instr_o
//   ifid_pc4_o     ifid_pc_o + 4 (wraps modulo 2^32)
//   ifid_instr_o   fetched instruction word
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_pc4_o,
  output logic [31:0] ifid_instr_o
);

  typedef enum logic [1:0] {
    S_START   = 2'd0,
    S_FETCH   = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] pend_pc_q;
  logic [31:0] hold_instr_q;
  logic        ifid_valid_q;
  logic [31:0] ifid_pc_q;
  logic [31:0] ifid_pc4_q;
  logic [31:0] ifid_instr_q;

  logic [31:0] redir_tgt;
  logic [31:0] pc_plus4;

  // Redirect targets are forced word aligned; pc+4 wraps naturally at 32 bits.
  assign redir_tgt = {redirect_pc_i[31:2], 2'b00};
  assign pc_plus4  = pc_q + 32'd4;

  // Request is decoded from state only, so no input reaches an output.
  assign imem_req_o   = (state_q == S_FETCH) || (state_q == S_DISCARD);
  assign imem_addr_o  = pc_q;
  assign pc_o         = pc_q;
  assign ifid_valid_o = ifid_valid_q;
  assign ifid_pc_o    = ifid_pc_q;
  assign ifid_pc4_o   = ifid_pc4_q;
  assign ifid_instr_o = ifid_instr_q;

  // Fetch FSM together with PC, pending-target, holding buffer and IF/ID.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= S_START;
      pc_q         <= RESET_PC;
      pend_pc_q    <= 32'h0000_0000;
      hold_instr_q <= 32'h0000_0000;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= 32'h0000_0000;
      ifid_pc4_q   <= 32'h0000_0000;
      ifid_instr_q <= 32'h0000_0000;
    end else begin
      case (state_q)
        S_START: begin
          state_q <= S_FETCH;
        end

        S_FETCH: begin
          if (redirect_i && imem_ready_i) begin
            // Returned word belongs to the wrong path; fetch the target next.
            pc_q         <= redir_tgt;
            ifid_valid_q <= 1'b0;
          end else if (redirect_i) begin
            // Address must stay stable until the memory answers, so park
            // the target and throw away the in-flight word later.
            pend_pc_q    <= redir_tgt;
            ifid_valid_q <= 1'b0;
            state_q      <= S_DISCARD;
          end else if (imem_ready_i && !stall_i) begin
            ifid_valid_q <= 1'b1;
            ifid_pc_q    <= pc_q;
            ifid_pc4_q   <= pc_plus4;
            ifid_instr_q <= imem_rdata_i;
            pc_q         <= pc_plus4;
          end else if (imem_ready_i) begin
            // Word arrived while decode is stalled: buffer it so it is
            // neither lost nor refetched.
            hold_instr_q <= imem_rdata_i;
            state_q      <= S_HOLD;
          end else if (!stall_i) begin
            ifid_valid_q <= 1'b0;
          end else begin
            ifid_valid_q <= ifid_valid_q;
          end
        end

        S_HOLD: begin
          if (redirect_i) begin
            pc_q         <= redir_tgt;
            ifid_valid_q <= 1'b0;
            state_q      <= S_FETCH;
          end else if (!stall_i) begin
            // pc still addresses the buffered word.
            ifid_valid_q <= 1'b1;
            ifid_pc_q    <= pc_q;
            ifid_pc4_q   <= pc_plus4;
            ifid_instr_q <= hold_instr_q;
            pc_q         <= pc_plus4;
            state_q      <= S_FETCH;
          end else begin
            state_q <= S_HOLD;
          end
        end

        S_DISCARD: begin
          ifid_valid_q <= 1'b0;
          if (imem_ready_i) begin
            // A redirect in the same cycle is younger than the parked one.
            pc_q    <= redirect_i ? redir_tgt : pend_pc_q;
            state_q <= S_FETCH;
          end else if (redirect_i) begin
            pend_pc_q <= redir_tgt;
          end else begin
            pend_pc_q <= pend_pc_q;
          end
        end

        default: begin
          state_q      <= S_START;
          ifid_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit. Two instances share the stimulus: dut0 with
//   the default reset PC and dut1 with a reset PC just below the 32-bit wrap.
//   Memory models return addr ^ 32'hA5A5_A5A5.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_ready;

  logic        req0, req1;
  logic [31:0] addr0, addr1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] pc0, pc1;
  logic        v0, v1;
  logic [31:0] ipc0, ipc1;
  logic [31:0] ipc4_0, ipc4_1;
  logic [31:0] instr0, instr1;

  int tests = 0;
  int fails = 0;

  assign rdata0 = addr0 ^ KEY;
  assign rdata1 = addr1 ^ KEY;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .imem_req_o(req0), .imem_addr_o(addr0),
    .imem_ready_i(imem_ready), .imem_rdata_i(rdata0), .pc_o(pc0),
    .ifid_valid_o(v0), .ifid_pc_o(ipc0), .ifid_pc4_o(ipc4_0),
    .ifid_instr_o(instr0)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .imem_req_o(req1), .imem_addr_o(addr1),
    .imem_ready_i(imem_ready), .imem_rdata_i(rdata1), .pc_o(pc1),
    .ifid_valid_o(v1), .ifid_pc_o(ipc1), .ifid_pc4_o(ipc4_1),
    .ifid_instr_o(instr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid0(input string tag, input logic [31:0] a);
    chk({tag, ".valid"}, {31'd0, v0}, 32'd1);
    chk({tag, ".pc"}, ipc0, a);
    chk({tag, ".pc4"}, ipc4_0, a + 32'd4);
    chk({tag, ".instr"}, instr0, a ^ KEY);
  endtask

  initial begin
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0000_0000;
    imem_ready  = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst.req", {31'd0, req0}, 32'd0);
    chk("rst.pc", pc0, 32'h0000_0000);
    chk("rst.valid", {31'd0, v0}, 32'd0);
    chk("rst.ifid_pc", ipc0, 32'h0000_0000);
    chk("rst.ifid_pc4", ipc4_0, 32'h0000_0000);
    chk("rst.instr", instr0, 32'h0000_0000);
    chk("rst.pc1", pc1, 32'hFFFF_FFF8);

    // Zero-wait streaming
    rst_n = 1'b1;
    tick();
    chk("start.req", {31'd0, req0}, 32'd1);
    chk("start.addr", addr0, 32'h0000_0000);
    chk("start.valid", {31'd0, v0}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_ifid0("stream", 32'(k * 4));
    end
    chk("stream.addr", addr0, 32'h0000_0010);

    // Stall 3 edges with ready=1: IF/ID frozen on 0xC, 0x10 is buffered
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_ifid0("stall.frozen", 32'h0000_000C);
    end
    chk("stall.req", {31'd0, req0}, 32'd0);
    stall = 1'b0;
    tick();
    chk_ifid0("stall.resume", 32'h0000_0010);
    tick();
    chk_ifid0("stall.next", 32'h0000_0014);

    // Redirect with ready=1 (low bits must be ignored)
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    chk("redir.valid", {31'd0, v0}, 32'd0);
    chk("redir.addr", addr0, 32'h0000_0100);
    tick();
    chk_ifid0("redir.target", 32'h0000_0100);

    // Redirect to 0x200 during a 3-cycle wait at 0x104
    imem_ready = 1'b0;
    tick();
    chk("wait.bubble", {31'd0, v0}, 32'd0);
    chk("wait.addr0", addr0, 32'h0000_0104);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    chk("wait.addr1", addr0, 32'h0000_0104);
    chk("wait.req1", {31'd0, req0}, 32'd1);
    chk("wait.valid1", {31'd0, v0}, 32'd0);
    tick();
    chk("wait.addr2", addr0, 32'h0000_0104);
    chk("wait.valid2", {31'd0, v0}, 32'd0);
    imem_ready = 1'b1;
    tick();
    chk("wait.newaddr", addr0, 32'h0000_0200);
    chk("wait.dropped", {31'd0, v0}, 32'd0);
    tick();
    chk_ifid0("wait.target", 32'h0000_0200);

    // Ready while stalled, then redirect in HOLD: buffered 0x204 never shown
    stall = 1'b1;
    tick();
    chk("hold.req", {31'd0, req0}, 32'd0);
    chk_ifid0("hold.frozen", 32'h0000_0200);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0040;
    tick();
    redirect = 1'b0;
    stall    = 1'b0;
    chk("hold.flush", {31'd0, v0}, 32'd0);
    chk("hold.addr", addr0, 32'h0000_0040);
    chk("hold.reqback", {31'd0, req0}, 32'd1);
    tick();
    chk_ifid0("hold.target", 32'h0000_0040);

    // Reset in the middle of a wait
    imem_ready = 1'b0;
    tick();
    chk("mrst.pre_addr", addr0, 32'h0000_0044);
    rst_n = 1'b0;
    tick();
    chk("mrst.req", {31'd0, req0}, 32'd0);
    chk("mrst.pc", pc0, 32'h0000_0000);
    chk("mrst.valid", {31'd0, v0}, 32'd0);
    chk("mrst.ifid_pc", ipc0, 32'h0000_0000);
    chk("mrst.ifid_pc4", ipc4_0, 32'h0000_0000);
    chk("mrst.instr", instr0, 32'h0000_0000);

    // Wrap-around from RESET_PC = FFFF_FFF8
    imem_ready = 1'b1;
    rst_n      = 1'b1;
    tick();
    chk("wrap.addr", addr1, 32'hFFFF_FFF8);
    tick();
    chk("wrap.pc_a", ipc1, 32'hFFFF_FFF8);
    chk("wrap.pc4_a", ipc4_1, 32'hFFFF_FFFC);
    chk("wrap.instr_a", instr1, 32'hFFFF_FFF8 ^ KEY);
    tick();
    chk("wrap.pc_b", ipc1, 32'hFFFF_FFFC);
    chk("wrap.pc4_b", ipc4_1, 32'h0000_0000);
    chk("wrap.valid_b", {31'd0, v1}, 32'd1);
    tick();
    chk("wrap.pc_c", ipc1, 32'h0000_0000);
    chk("wrap.pc4_c", ipc4_1, 32'h0000_0004);
    chk("wrap.instr_c", instr1, KEY);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined core. Owns the architectural fetch PC and drives a request/ready instruction-memory port. Captures each returned instruction into the IF/ID pipeline register as valid/pc/pc+4/instr. Honours hazard-unit stalls and branch/jump redirects, including redirects that arrive while a memory request is still outstanding.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0
- clk  in  1  rising-edge clock, the only clock
- rst_n  in  1  reset, synchronous, active-low
- stall  in  1  hazard unit: hold IF/ID and PC
- redirect  in  1  taken branch/jump this cycle
- redirect_pc  in  32  target address; bits [1:0] ignored and treated as 0
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, equals pc
- imem_ready  in  1  memory completes the request this cycle
- imem_rdata  in  32  instruction, valid when imem_req && imem_ready
- pc  out  32  current fetch PC
- ifid_valid  out  1  IF/ID holds a live instruction
- ifid_pc  out  32  address of ifid_instr
- ifid_pc4  out  32  ifid_pc + 4
- ifid_instr  out  32  fetched instruction word

## Operation
- States: START, FETCH, HOLD, DISCARD. Registers: pc, pend_pc, hold_instr, and the IF/ID fields.
- Reset, sampled at a posedge with rst_n=0, has priority over everything:
  - state=START, pc=RESET_PC, pend_pc=0, hold_instr=0.
  - ifid_valid=0, ifid_pc=0, ifid_pc4=0, ifid_instr=0.
  - Reset mid-request abandons the request. The memory must tolerate imem_req dropping.
- imem_req=1 in FETCH and DISCARD, 0 in START and HOLD. imem_addr=pc always.
- START: go to FETCH unconditionally.
- FETCH, in priority order:
  - redirect && imem_ready: drop rdata; pc<=redirect_pc; ifid_valid<=0; stay in FETCH.
  - redirect && !imem_ready: pend_pc<=redirect_pc; ifid_valid<=0; go to DISCARD. The address is held because it must stay stable until ready.
  - imem_ready && !stall: ifid<={1, pc, pc+4, rdata}; pc<=pc+4.
  - imem_ready && stall: hold_instr<=rdata; IF/ID unchanged; go to HOLD.
  - !imem_ready && !stall: ifid_valid<=0 (bubble).
  - !imem_ready && stall: IF/ID unchanged.
- HOLD:
  - redirect: pc<=redirect_pc; ifid_valid<=0; go to FETCH.
  - !stall: ifid<={1, pc, pc+4, hold_instr}; pc<=pc+4; go to FETCH.
  - otherwise: stay in HOLD.
- DISCARD:
  - IF/ID stays invalid.
  - A new redirect overwrites pend_pc.
  - On imem_ready: drop rdata; pc<=pend_pc, or redirect_pc if redirect is asserted that same cycle; go to FETCH.
- Redirect always beats stall and flushes IF/ID.
- Arithmetic is modulo 2^32: pc=32'hFFFF_FFFC advances to 0, and ifid_pc4 wraps the same way.

## Timing
- Zero-wait memory (imem_ready tied 1, no stall): one instruction per cycle. The instruction requested in cycle N appears on IF/ID in cycle N+1.
- Redirect sampled at edge E with no request pending: imem_addr=redirect_pc from E. That target reaches IF/ID one edge after it is accepted.
- Redirect during a wait: the target is requested the cycle after the old request's ready.
- Stall is level-sensitive. IF/ID is frozen for exactly the stalled edges, and no fetched instruction is lost or duplicated.
- All outputs are registered or decoded from state/pc only. There is no combinational path from any input to any output.

## Test plan
- Reset, then imem_ready=1 with memory returning addr^32'hA5A5_A5A5 -> ifid_pc walks 0,4,8,… from the second cycle after rst_n rises; ifid_instr matches.
- Stall for 3 cycles mid-stream, ready=1 -> IF/ID holds one instruction for 3 cycles, then resumes with the next sequential address; no gap, no duplicate.
- Redirect to 0x100 with ready=1 -> next imem_addr=0x100; ifid_valid=0 for one cycle; then ifid_pc=0x100.
- Redirect to 0x200 during a 3-cycle memory wait -> addr stays on the old pc until ready; old data is dropped; next request is 0x200; no valid instruction from the old address.
- Ready arrives while stall=1, then redirect to 0x40 in HOLD -> buffered instruction is never presented; next fetch is 0x40.
- RESET_PC=32'hFFFF_FFF8, ready=1 -> ifid_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; at FFFF_FFFC, ifid_pc4=0. Also assert rst_n=0 mid-wait -> all outputs return to reset values next edge.
